// File: rtl/nota_pkg.sv
// Shared types and constants for the grade player and the A/P/F classifier.
// Grade width, legal maximum, player FSM states and the display letter codes.
package nota_pkg;

  localparam int unsigned NOTA_W   = 4;
  localparam int unsigned NOTA_MAX = 10;

  typedef logic [NOTA_W-1:0] nota_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } player_state_t;

  // Seven-segment patterns {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] LETRA_A = 7'b1110111;
  localparam logic [6:0] LETRA_P = 7'b1110011;
  localparam logic [6:0] LETRA_F = 7'b1110001;

endpackage

// File: rtl/nota_mem.sv
// Grade storage: synchronous write, asynchronous read, no reset on the array.
module nota_mem #(
  parameter int unsigned NSLOTS = 8,
  parameter int unsigned NOTA_W = 4,
  parameter int unsigned ADDR_W = $clog2(NSLOTS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [NOTA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [NOTA_W-1:0] rdata_o
);

  logic [NOTA_W-1:0] mem_q [NSLOTS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nota_player.sv
// Captures up to NSLOTS grades from the switches and streams them out over
// a valid/ready link; outputs are decoded from registered state only.
module nota_player #(
  parameter int unsigned NSLOTS   = 8,
  parameter int unsigned NOTA_W   = nota_pkg::NOTA_W,
  parameter int unsigned NOTA_MAX = nota_pkg::NOTA_MAX,
  parameter int unsigned CNT_W    = $clog2(NSLOTS + 1)
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [NOTA_W-1:0] wr_nota,
  input  logic              clear,
  input  logic              play,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [NOTA_W-1:0] out_nota,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import nota_pkg::*;

  localparam int unsigned PTR_W = $clog2(NSLOTS);
  localparam logic [NOTA_W-1:0] MaxNota = NOTA_W'(NOTA_MAX);

  player_state_t     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              full_int;
  logic              last_xfer;
  logic [NOTA_W-1:0] rd_data;

  assign full_int  = (count_q == CNT_W'(NSLOTS));
  assign last_xfer = ({1'b0, rd_ptr_q} == CNT_W'(count_q - CNT_W'(1)));

  nota_mem #(
    .NSLOTS (NSLOTS),
    .NOTA_W (NOTA_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk_i   (clk_2),
    .we_i    (mem_we),
    .waddr_i (count_q[PTR_W-1:0]),
    .wdata_i (wr_nota),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          count_d = '0;
          err_d   = wr_en;
        end else if (play) begin
          rd_ptr_d = '0;
          state_d  = (count_q != '0) ? PLAY : DONE;
          err_d    = wr_en;
        end else if (wr_en) begin
          if (full_int || (wr_nota > MaxNota)) begin
            err_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      PLAY: begin
        err_d = wr_en;
        // out_valid is implied by PLAY, so ready alone marks a transfer.
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (last_xfer) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        err_d   = wr_en;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Storage is frozen during PLAY, so the async read is stable under backpressure.
  assign out_valid = (state_q == PLAY);
  assign out_nota  = out_valid ? rd_data : '0;
  assign busy      = (state_q == PLAY);
  assign done      = (state_q == DONE);
  assign count     = count_q;
  assign full      = full_int;
  assign err       = err_q;

endmodule

// File: tb/tb_nota_player.sv
// Directed bench for nota_player: a vector table for the basic flow plus
// hand-written sequences for backpressure, capacity, collisions and reset.
module tb_nota_player;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [3:0] wr_nota;
  logic       clear;
  logic       play;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_nota;
  logic [3:0] count;
  logic       full;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  nota_player #(
    .NSLOTS   (8),
    .NOTA_W   (4),
    .NOTA_MAX (10)
  ) dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_nota   (wr_nota),
    .clear     (clear),
    .play      (play),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_nota  (out_nota),
    .count     (count),
    .full      (full),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic       wr_en;
    logic [3:0] wr_nota;
    logic       clear;
    logic       play;
    logic       ready;
    logic [3:0] e_count;
    logic       e_full;
    logic       e_err;
    logic       e_valid;
    logic [3:0] e_nota;
    logic       e_done;
    logic       e_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_nota = 4'd0; clear = 1'b0; play = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic write(input logic [3:0] n);
    wr_en = 1'b1; wr_nota = n;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    //             wr  nota clr ply rdy  cnt full err val nota done busy
    vecs[0]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'd7,  1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'd3,  1'b0, 1'b1};
    vecs[5]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'd10, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0};

    do_reset();
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_nota", out_nota, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // Basic write/play/range/clear flow.
    for (int i = 0; i < 11; i++) begin
      wr_en = vecs[i].wr_en; wr_nota = vecs[i].wr_nota; clear = vecs[i].clear;
      play = vecs[i].play; out_ready = vecs[i].ready;
      step();
      chk($sformatf("v%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("v%0d_full", i), full, vecs[i].e_full);
      chk($sformatf("v%0d_err", i), err, vecs[i].e_err);
      chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_nota", i), out_nota, vecs[i].e_nota);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
    end
    idle_inputs();

    // Backpressure: {5, 9}, ready low for three cycles.
    do_reset();
    write(4'd5);
    write(4'd9);
    play = 1'b1;
    step();
    play = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_hold_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_hold_nota%0d", i), out_nota, 5);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_second_nota", out_nota, 9);
    chk("bp_second_valid", out_valid, 1);
    step();
    chk("bp_done", done, 1);
    chk("bp_valid_off", out_valid, 0);
    out_ready = 1'b0;
    step();
    chk("bp_idle_done", done, 0);

    // Capacity: eight grades fill, ninth rejected.
    do_reset();
    for (int i = 0; i < 8; i++) write(4'(i + 1));
    chk("cap_count", count, 8);
    chk("cap_full", full, 1);
    write(4'd2);
    chk("cap_err", err, 1);
    chk("cap_count_kept", count, 8);
    step();
    chk("cap_err_pulse", err, 0);
    // Last slot must hold the eighth grade.
    play = 1'b1; out_ready = 1'b1;
    step();
    play = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("cap_last_nota", out_nota, 8);
    step();
    chk("cap_done", done, 1);
    out_ready = 1'b0;

    // Empty play.
    do_reset();
    play = 1'b1;
    step();
    play = 1'b0;
    chk("empty_done", done, 1);
    chk("empty_valid", out_valid, 0);
    chk("empty_busy", busy, 0);
    step();
    chk("empty_done_pulse", done, 0);
    chk("empty_valid2", out_valid, 0);

    // clear + play with two stored.
    do_reset();
    write(4'd6);
    write(4'd8);
    chk("cp_count_pre", count, 2);
    clear = 1'b1; play = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0; play = 1'b0;
    chk("cp_count", count, 0);
    chk("cp_valid", out_valid, 0);
    chk("cp_done", done, 0);
    step();
    chk("cp_valid2", out_valid, 0);
    out_ready = 1'b0;

    // wr_en + play with {4}.
    do_reset();
    write(4'd4);
    wr_en = 1'b1; wr_nota = 4'd6; play = 1'b1; out_ready = 1'b1;
    step();
    wr_en = 1'b0; play = 1'b0;
    chk("wp_err", err, 1);
    chk("wp_valid", out_valid, 1);
    chk("wp_nota", out_nota, 4);
    chk("wp_count", count, 1);
    step();
    chk("wp_done", done, 1);
    chk("wp_valid_off", out_valid, 0);
    chk("wp_err_pulse", err, 0);
    out_ready = 1'b0;

    // Reset mid-PLAY.
    do_reset();
    write(4'd1);
    write(4'd2);
    write(4'd3);
    play = 1'b1; out_ready = 1'b1;
    step();
    play = 1'b0;
    chk("rp_first", out_nota, 1);
    step();
    chk("rp_second", out_nota, 2);
    reset_n = 1'b0;
    #1;
    chk("rp_async_valid", out_valid, 0);
    chk("rp_async_nota", out_nota, 0);
    chk("rp_async_busy", busy, 0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b0;
    step();
    chk("rp_count", count, 0);
    chk("rp_busy", busy, 0);
    chk("rp_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nota_player.md
# nota_player

Grade transmitter: captures up to NSLOTS student grades (0–10) entered from the switches, then streams them one at a time over a valid/ready link. The downstream consumer is the grade classifier that drives the A/P/F letter on the seven-segment display. It sits between the switch bank in `top` and the classifier, so a whole class is graded in sequence instead of one grade per switch setting.

## Interface
- `NSLOTS`, 8: grade storage depth; power of two, ≥2.
- `NOTA_W`, 4: grade width.
- `NOTA_MAX`, 10: highest legal grade.

- `clk_2`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  capture `wr_nota` this cycle (level-sampled, one grade per high cycle).
- `wr_nota`  in  NOTA_W  grade to store.
- `clear`  in  1  empty storage.
- `play`  in  1  start playback.
- `out_ready`  in  1  consumer accepts `out_nota`.
- `out_valid`  out  1  `out_nota` holds a grade.
- `out_nota`  out  NOTA_W  current grade.
- `count`  out  $clog2(NSLOTS+1)  grades stored.
- `full`  out  1  `count == NSLOTS`.
- `busy`  out  1  state is PLAY.
- `done`  out  1  one-cycle pulse at end of playback.
- `err`  out  1  one-cycle pulse on a rejected write.

## Operation
- FSM states: IDLE, PLAY, DONE.
- IDLE: accepts writes, clear and play.
  - `wr_en` with `wr_nota ≤ NOTA_MAX` and not full: store at slot `count`, increment `count`.
  - `wr_en` when full, with `wr_nota > NOTA_MAX`, or together with `play` or `clear`: grade not stored, `err` pulses.
- Priority in IDLE: `clear` > `play` > `wr_en`.
  - `clear` sets `count` to 0. Stored data is don't-care.
- `play` in IDLE: `rd_ptr` set to 0.
  - Next state is PLAY if `count > 0`, else DONE.
- PLAY:
  - `out_valid` = 1 and `out_nota` = slot[`rd_ptr`].
  - On valid & ready, `rd_ptr` increments.
  - When the transfer is for slot `count-1`, next state is DONE.
  - `wr_en`, `clear` and `play` are ignored; `err` pulses if `wr_en` is high.
- DONE: `done` = 1 for one cycle, then IDLE. Storage and `count` are preserved, so replay is allowed.
- Outputs are registered or decoded from state only. No combinational path from `out_ready` to `out_valid` or `out_nota`.

## Timing
- Reset values: state IDLE, `count` 0, `rd_ptr` 0, `out_valid` 0, `out_nota` 0, `full` 0, `busy` 0, `done` 0, `err` 0.
- Asserting `reset_n` low during PLAY drops `out_valid` immediately, without waiting for a clock edge.
- Write latency: `count`/`full` update one cycle after the `wr_en` edge.
- `err` is high in the cycle following the rejected edge.
- Playback start:
  - `play` sampled at edge k gives `out_valid` = 1 and `busy` = 1 in cycle k+1.
  - With `count = 0`, `done` = 1 in cycle k+1 and `out_valid` stays 0.
- Handshake:
  - A transfer occurs at an edge where `out_valid` & `out_ready`.
  - While `out_valid` & !`out_ready`, `out_nota` must hold stable.
  - With `out_ready` held high, one grade transfers per cycle.
- End of playback: if the last transfer is at edge t, then `out_valid` = 0 and `done` = 1 in cycle t+1, and IDLE in t+2.
- `out_nota` is 0 whenever `out_valid` = 0.

## Structure
- Package `nota_pkg` holds:
  - `nota_t` (logic [NOTA_W-1:0])
  - `NOTA_MAX`
  - FSM enum `player_state_t` {IDLE, PLAY, DONE}
  - letter constants LETRA_A/P/F, shared with the classifier
- Storage is one sub-module `nota_mem`: NSLOTS × NOTA_W, synchronous write, asynchronous read, no reset on the array.
- `nota_player` contains the FSM, pointers and counters.

## Test plan
- Reset, then write grades 7, 3, 10 (one per cycle) → `count` = 3 and `full` = 0. Then `play` with `out_ready` = 1 → `out_nota` = 7, 3, 10 in consecutive cycles, then `done` pulse, then IDLE.
- Backpressure: stored {5, 9}, play, `out_ready` low for 3 cycles → `out_nota` holds 5 with `out_valid` = 1 for all 3 cycles. Raise `out_ready` → 5 then 9 transfer.
- Capacity and range:
  - Write 8 grades → `full` = 1. A 9th write is rejected with an `err` pulse and `count` stays 8.
  - In a separate run, write 11 → `err` pulse and `count` unchanged.
- Empty play: reset, `play` → `done` = 1 the next cycle, `out_valid` never 1.
- Simultaneous events in IDLE:
  - `clear` + `play` with `count` = 2 → `count` = 0, no playback.
  - `wr_en` + `play` with {4} stored → `err` pulses and playback emits only 4.
- Reset mid-PLAY: stored {1, 2, 3}, after the first transfer drive `reset_n` low → `out_valid` = 0 before the next edge. After release: IDLE, `count` = 0.
